// File: rtl/vga_pkg.sv
// Shared VGA bus layout and label-region geometry; the label address generator imports the same
// constants so its char_addr regions and this consumer's pixel regions agree.
package vga_pkg;

  localparam int VGA_BUS_W = 38;

  typedef struct packed {
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;
  } vga_bus_t;

  localparam logic [10:0] LABEL_H_X0   = 11'd256;
  localparam logic [10:0] LABEL_H_X1   = 11'd768;
  localparam logic [10:0] LABEL_TOP_Y0 = 11'd104;
  localparam logic [10:0] LABEL_TOP_Y1 = 11'd120;
  localparam logic [10:0] LABEL_BOT_Y0 = 11'd648;
  localparam logic [10:0] LABEL_BOT_Y1 = 11'd664;
  localparam logic [10:0] LABEL_V_Y0   = 11'd128;
  localparam logic [10:0] LABEL_V_Y1   = 11'd640;
  localparam logic [10:0] LABEL_L_X0   = 11'd236;
  localparam logic [10:0] LABEL_R_X0   = 11'd780;
  localparam logic [10:0] LABEL_W      = 11'd8;
  localparam logic [10:0] CHAR_OFF_X   = 11'd28;
  localparam logic [10:0] CHAR_OFF_Y0  = 11'd24;
  localparam logic [10:0] CHAR_OFF_Y1  = 11'd40;

  function automatic logic in_range(input logic [10:0] x, input logic [10:0] lo,
                                    input logic [10:0] hi);
    return (x >= lo) && (x <= hi);
  endfunction

endpackage

// File: rtl/vga_delay.sv
// Async-reset shift register delaying a packed bus by CLK_DEL cycles; CLK_DEL=0 is a wire.
module vga_delay #(
  parameter int WIDTH   = 38,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  generate
    if (CLK_DEL == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign dout_o = din_i;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_q [CLK_DEL];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < CLK_DEL; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= din_i;
          for (int i = 1; i < CLK_DEL; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign dout_o = stage_q[CLK_DEL-1];
    end
  endgenerate

endmodule

// File: rtl/draw_letters.sv
// Overlays font-ROM glyph pixels on the VGA stream: bus is delayed to meet the ROM row, the glyph
// column bit is selected at that aligned stage, and everything lands in one output register.
module draw_letters
  import vga_pkg::*;
#(
  parameter int          ROM_LATENCY = 1,
  parameter logic [11:0] TEXT_RGB    = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [7:0]  char_pixels,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [11:0] rgb_out
);

  vga_bus_t    in_bus, al_bus, out_d, out_q;
  logic [10:0] hc, vc, hc_lo, vc_lo, col;
  logic        h_win, v_win, glyph_bit;

  assign in_bus = {vcount_in, vsync_in, vblnk_in, hcount_in, hsync_in, hblnk_in, rgb_in};

  vga_delay #(.WIDTH(VGA_BUS_W), .CLK_DEL(ROM_LATENCY)) u_align (
    .clk    (clk),
    .rst_n  (rst_n),
    .din_i  (in_bus),
    .dout_o (al_bus)
  );

  assign hc    = al_bus.hcount;
  assign vc    = al_bus.vcount;
  assign hc_lo = {5'd0, hc[5:0]};
  assign vc_lo = {5'd0, vc[5:0]};

  always_comb begin
    h_win = in_range(hc, LABEL_H_X0, LABEL_H_X1) &&
            (in_range(vc, LABEL_TOP_Y0, LABEL_TOP_Y1) || in_range(vc, LABEL_BOT_Y0, LABEL_BOT_Y1)) &&
            in_range(hc_lo, CHAR_OFF_X, CHAR_OFF_X + LABEL_W - 11'd1);
    // Side windows are LABEL_W+1 wide; the extra column is a spacer and never lights up.
    v_win = !h_win && in_range(vc, LABEL_V_Y0, LABEL_V_Y1) &&
            in_range(vc_lo, CHAR_OFF_Y0, CHAR_OFF_Y1) &&
            (in_range(hc, LABEL_L_X0, LABEL_L_X0 + LABEL_W) ||
             in_range(hc, LABEL_R_X0, LABEL_R_X0 + LABEL_W));
    if (h_win)                              col = hc_lo - CHAR_OFF_X;
    else if (hc <= LABEL_L_X0 + LABEL_W)    col = hc - LABEL_L_X0;
    else                                    col = hc - LABEL_R_X0;
    glyph_bit = (col <= 11'd7) ? char_pixels[3'd7 - col[2:0]] : 1'b0;

    out_d = al_bus;
    if (al_bus.vblnk || al_bus.hblnk)        out_d.rgb = 12'h000;
    else if ((h_win || v_win) && glyph_bit)  out_d.rgb = TEXT_RGB;
    else                                     out_d.rgb = al_bus.rgb;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= '0;
    else        out_q <= out_d;
  end

  assign vcount_out = out_q.vcount;
  assign vsync_out  = out_q.vsync;
  assign vblnk_out  = out_q.vblnk;
  assign hcount_out = out_q.hcount;
  assign hsync_out  = out_q.hsync;
  assign hblnk_out  = out_q.hblnk;
  assign rgb_out    = out_q.rgb;

endmodule

// File: tb/tb_draw_letters.sv
// Bench for draw_letters at ROM_LATENCY=1 and 2: spec-level pixel model checked every cycle, plus
// hand-computed pixel cases, reset release timing and an asynchronous mid-line reset.
module tb_draw_letters;

  typedef struct packed {
    logic [10:0] vc;
    logic        vs;
    logic        vb;
    logic [10:0] hc;
    logic        hs;
    logic        hb;
    logic [11:0] rgb;
  } bus_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [10:0] vcount_in = '0, hcount_in = '0;
  logic        vsync_in = 1'b0, vblnk_in = 1'b0, hsync_in = 1'b0, hblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [7:0]  cp1 = '0, cp2 = '0;

  logic [10:0] o1_vc, o1_hc, o2_vc, o2_hc;
  logic        o1_vs, o1_vb, o1_hs, o1_hb, o2_vs, o2_vb, o2_hs, o2_hb;
  logic [11:0] o1_rgb, o2_rgb;

  draw_letters #(.ROM_LATENCY(1), .TEXT_RGB(12'hFFF)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .rgb_in(rgb_in), .char_pixels(cp1),
    .vcount_out(o1_vc), .vsync_out(o1_vs), .vblnk_out(o1_vb),
    .hcount_out(o1_hc), .hsync_out(o1_hs), .hblnk_out(o1_hb), .rgb_out(o1_rgb)
  );

  draw_letters #(.ROM_LATENCY(2), .TEXT_RGB(12'hFFF)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .rgb_in(rgb_in), .char_pixels(cp2),
    .vcount_out(o2_vc), .vsync_out(o2_vs), .vblnk_out(o2_vb),
    .hcount_out(o2_hc), .hsync_out(o2_hs), .hblnk_out(o2_hb), .rgb_out(o2_rgb)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic bus_t cur_in();
    return {vcount_in, vsync_in, vblnk_in, hcount_in, hsync_in, hblnk_in, rgb_in};
  endfunction

  function automatic bus_t out1();
    return {o1_vc, o1_vs, o1_vb, o1_hc, o1_hs, o1_hb, o1_rgb};
  endfunction

  function automatic bus_t out2();
    return {o2_vc, o2_vs, o2_vb, o2_hc, o2_hs, o2_hb, o2_rgb};
  endfunction

  // Pixel rules restated with plain integer arithmetic.
  function automatic bus_t model(bus_t a, logic [7:0] cp);
    int   hc = int'(a.hc);
    int   vc = int'(a.vc);
    int   hm = hc % 64;
    int   vm = vc % 64;
    int   col = 99;
    bit   hl, vl, on;
    bus_t r = a;
    hl = (hc >= 256) && (hc <= 768) &&
         (((vc >= 104) && (vc <= 120)) || ((vc >= 648) && (vc <= 664))) &&
         (hm >= 28) && (hm <= 35);
    vl = !hl && (vc >= 128) && (vc <= 640) && (vm >= 24) && (vm <= 40) &&
         (((hc >= 236) && (hc <= 244)) || ((hc >= 780) && (hc <= 788)));
    if (hl)      col = hm - 28;
    else if (vl) col = (hc <= 244) ? hc - 236 : hc - 780;
    on = (col >= 0) && (col <= 7) && cp[7-col];
    if (a.vb || a.hb) r.rgb = 12'h000;
    else if (on)      r.rgb = 12'hFFF;
    else              r.rgb = a.rgb;
    return r;
  endfunction

  task automatic chk(input string name, input logic [37:0] act, input logic [37:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // scoreboard: input history, newest at the back
  bus_t hist[$];
  bus_t e1, e2;

  always @(posedge clk) begin
    if (!rst_n) begin
      hist = '{bus_t'(0), bus_t'(0), bus_t'(0)};
      e1 = '0;
      e2 = '0;
    end else begin
      hist.push_back(cur_in());
      if (hist.size() > 6) void'(hist.pop_front());
      e1 = model(hist[hist.size()-2], cp1);
      e2 = model(hist[hist.size()-3], cp2);
    end
    #1;
    chk("bus_L1", out1(), e1);
    chk("bus_L2", out2(), e2);
  end

  // driver tasks
  task automatic drive_random();
    vcount_in = 11'($urandom);
    hcount_in = 11'($urandom);
    vsync_in  = 1'($urandom);
    vblnk_in  = ($urandom_range(0, 15) == 0);
    hsync_in  = 1'($urandom);
    hblnk_in  = ($urandom_range(0, 15) == 0);
    rgb_in    = 12'($urandom);
    cp1       = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
    cp2       = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
  endtask

  // One pixel on dut1: inputs, then the ROM row one cycle later, then check two clocks after input.
  task automatic pin(input string name, input int hc, input int vc, input logic hb,
                     input logic [11:0] rgb, input logic [7:0] cp, input logic [11:0] exp_rgb);
    @(negedge clk);
    hcount_in = 11'(hc); vcount_in = 11'(vc); hblnk_in = hb; vblnk_in = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0; rgb_in = rgb; cp1 = 8'($urandom); cp2 = 8'($urandom);
    @(negedge clk);
    hcount_in = '0; vcount_in = '0; hblnk_in = 1'b0; rgb_in = '0; cp1 = cp; cp2 = 8'($urandom);
    @(negedge clk);
    chk({name, "_rgb"}, 38'(o1_rgb), 38'(exp_rgb));
    chk({name, "_hc"}, 38'(o1_hc), 38'(hc));
    chk({name, "_hblnk"}, 38'(o1_hb), 38'(hb));
  endtask

  int lines[20] = '{104, 110, 120, 121, 103, 648, 656, 664, 665, 128,
                    127, 152, 156, 168, 169, 640, 641, 200, 300, 10};

  initial begin
    // reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive_random();
    end
    @(negedge clk);
    chk("reset_hold", 38'(out1()), 38'd0);
    rst_n = 1'b1;
    hcount_in = 11'd400; vcount_in = 11'd300; rgb_in = 12'h123;
    hblnk_in = 1'b0; vblnk_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    @(posedge clk); #1;
    chk("release_1clk", 38'(o1_rgb), 38'd0);
    @(posedge clk); #1;
    chk("release_2clk", 38'(o1_rgb), 38'h123);

    pin("top_A_col0", 284, 110, 1'b0, 12'h0A0, 8'h80, 12'hFFF);
    pin("top_A_col1", 285, 110, 1'b0, 12'h0A0, 8'h80, 12'h0A0);
    for (int h = 236; h <= 244; h++)
      pin("side_8", h, 156, 1'b0, 12'h05A, 8'hFF, (h <= 243) ? 12'hFFF : 12'h05A);
    pin("outside", 400, 300, 1'b0, 12'h3C5, 8'hFF, 12'h3C5);
    pin("blank", 284, 110, 1'b1, 12'h0A0, 8'hFF, 12'h000);

    // line sweeps through and around the label bands, with one async reset mid-line
    for (int l = 0; l < 20; l++) begin
      for (int h = 0; h < 1024; h++) begin
        @(negedge clk);
        vcount_in = 11'(lines[l]);
        hcount_in = 11'(h);
        hblnk_in  = (h >= 1000) || ($urandom_range(0, 31) == 0);
        vblnk_in  = ($urandom_range(0, 63) == 0);
        hsync_in  = 1'($urandom);
        vsync_in  = 1'($urandom);
        rgb_in    = 12'($urandom);
        cp1       = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        cp2       = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        if (l == 3 && h == 512) begin
          rst_n = 1'b0;
          #1;
          chk("async_clr_L1", 38'(out1()), 38'd0);
          chk("async_clr_L2", 38'(out2()), 38'd0);
        end
        if (l == 3 && h == 515) rst_n = 1'b1;
      end
    end

    // fully random counts, including values beyond the visible frame
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      drive_random();
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
